// File: rtl/operand_fetch.sv
// ============================================================================
// Module   : operand_fetch
// Purpose  : Register-read stage with write-back bypass and busy scoreboard,
//            handing rs1/rs2 operands to the execute stage through a
//            registered valid/ready output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } decoded_instr_t;
endpackage

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  decoded_instr_t           in_instr,
  input  logic [$clog2(NREGS)-1:0] in_rs1_addr,
  input  logic [$clog2(NREGS)-1:0] in_rs2_addr,
  input  logic                     in_rs1_use,
  input  logic                     in_rs2_use,
  input  logic [$clog2(NREGS)-1:0] in_rd_addr,
  input  logic                     in_rd_we,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_rs1,
  output logic [XLEN-1:0]          out_rs2,
  output decoded_instr_t           out_instr,
  output logic [$clog2(NREGS)-1:0] out_rd_addr,
  output logic                     out_rd_we
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             out_valid_q;
  logic [XLEN-1:0]  out_rs1_q;
  logic [XLEN-1:0]  out_rs2_q;
  decoded_instr_t   out_instr_q;
  logic [AW-1:0]    out_rd_addr_q;
  logic             out_rd_we_q;

  logic             w_wb_write;
  logic             w_hazard;
  logic             w_fire;
  logic [XLEN-1:0]  w_src1;
  logic [XLEN-1:0]  w_src2;

  assign w_wb_write = wb_en && (wb_addr != '0);

  function automatic logic [XLEN-1:0] read_src(input logic [AW-1:0] a);
    if (a == '0)
      return '0;
    else if (wb_en && (wb_addr == a))
      return wb_data;
    else
      return rf_q[a];
  endfunction

  // A write-back landing this cycle resolves the pending writer.
  function automatic logic busy_eff(input logic [AW-1:0] a);
    return busy_q[a] && !(wb_en && (wb_addr == a));
  endfunction

  always_comb begin
    w_src1   = read_src(in_rs1_addr);
    w_src2   = read_src(in_rs2_addr);
    w_hazard = (in_rs1_use && busy_eff(in_rs1_addr)) ||
               (in_rs2_use && busy_eff(in_rs2_addr)) ||
               (in_rd_we && (in_rd_addr != '0) && busy_eff(in_rd_addr));
  end

  assign in_ready = !w_hazard && (!out_valid_q || out_ready);
  assign w_fire   = in_valid && in_ready;

  // Set after clear so a new writer stays pending over a same-index write-back.
  always_comb begin
    busy_d = busy_q;
    if (w_wb_write)
      busy_d[wb_addr] = 1'b0;
    if (w_fire && in_rd_we && (in_rd_addr != '0))
      busy_d[in_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        rf_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (w_wb_write)
        rf_q[wb_addr] <= wb_data;
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_instr_q   <= '0;
      out_rd_addr_q <= '0;
      out_rd_we_q   <= 1'b0;
    end else if (w_fire) begin
      out_valid_q   <= 1'b1;
      out_rs1_q     <= w_src1;
      out_rs2_q     <= w_src2;
      out_instr_q   <= in_instr;
      out_rd_addr_q <= in_rd_addr;
      out_rd_we_q   <= in_rd_we;
    end else if (out_valid_q && out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_instr   = out_instr_q;
  assign out_rd_addr = out_rd_addr_q;
  assign out_rd_we   = out_rd_we_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed self-checking bench for operand_fetch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  decoded_instr_t in_instr;
  logic [4:0]     in_rs1_addr;
  logic [4:0]     in_rs2_addr;
  logic           in_rs1_use;
  logic           in_rs2_use;
  logic [4:0]     in_rd_addr;
  logic           in_rd_we;
  logic           wb_en;
  logic [4:0]     wb_addr;
  logic [31:0]    wb_data;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_rs1;
  logic [31:0]    out_rs2;
  decoded_instr_t out_instr;
  logic [4:0]     out_rd_addr;
  logic           out_rd_we;

  int total = 0;
  int bad   = 0;

  operand_fetch #(.XLEN(32), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_rs1_addr(in_rs1_addr),
    .in_rs2_addr(in_rs2_addr),
    .in_rs1_use (in_rs1_use),
    .in_rs2_use (in_rs2_use),
    .in_rd_addr (in_rd_addr),
    .in_rd_we   (in_rd_we),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_instr  (out_instr),
    .out_rd_addr(out_rd_addr),
    .out_rd_we  (out_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic decoded_instr_t mk(input logic [6:0] op, input logic [31:0] imm);
    decoded_instr_t d;
    d.opcode = op;
    d.funct3 = 3'd1;
    d.funct7 = 7'h20;
    d.imm    = imm;
    return d;
  endfunction

  task automatic issue(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input decoded_instr_t ins);
    in_valid    = v;
    in_rs1_addr = rs1;
    in_rs1_use  = u1;
    in_rs2_addr = rs2;
    in_rs2_use  = u2;
    in_rd_addr  = rd;
    in_rd_we    = we;
    in_instr    = ins;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
  endtask

  initial begin
    decoded_instr_t ia, ib;
    ia = mk(7'h33, 32'h0000_00A1);
    ib = mk(7'h13, 32'h0000_0B0B);

    rst_n = 1'b0;
    out_ready = 1'b1;
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    wb(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_rs1", out_rs1, 0);
    chk("reset_out_rs2", out_rs2, 0);
    chk("reset_out_instr", out_instr, 0);
    chk("reset_out_rd", {out_rd_we, out_rd_addr}, 0);
    chk("reset_in_ready", in_ready, 1);

    // wb x5 then add x6,x5,x0
    wb(1'b1, 5'd5, 32'h0000_1234);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, ia);
    #1;
    chk("add_in_ready", in_ready, 1);
    chk("add_pre_valid", out_valid, 0);
    tick();
    issue(1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    #1;
    chk("add_out_valid", out_valid, 1);
    chk("add_out_rs1", out_rs1, 32'h0000_1234);
    chk("add_out_rs2", out_rs2, 0);
    chk("add_out_rd", {out_rd_we, out_rd_addr}, {1'b1, 5'd6});
    chk("add_out_instr", out_instr, ia);
    chk("x6_busy_stalls_reader", in_ready, 0);
    tick();
    chk("drain_out_valid", out_valid, 0);
    chk("drain_hold_rs1", out_rs1, 32'h0000_1234);

    // RAW on x7 resolved by same-cycle write-back bypass
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, ia);
    tick();
    issue(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, ib);
    #1;
    chk("raw_x7_stall", in_ready, 0);
    tick();
    chk("raw_x7_valid_drop", out_valid, 0);
    chk("raw_x7_still_stall", in_ready, 0);
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    #1;
    chk("raw_x7_ready_on_wb", in_ready, 1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    #1;
    chk("bypass_out_valid", out_valid, 1);
    chk("bypass_out_rs1", out_rs1, 32'hDEAD_BEEF);
    chk("bypass_out_rd", out_rd_addr, 5'd8);

    // x0 stays zero; rd=x0 never stalls
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, ia);
    #1;
    chk("x0_rd_ready", in_ready, 1);
    tick();
    chk("x0_read_zero", out_rs1, 0);
    chk("x7_from_rf", out_rs2, 32'hDEAD_BEEF);
    chk("x0_rd_ready_again", in_ready, 1);

    // backpressure: A held, B waits, late wb does not disturb A
    issue(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ia);
    tick();
    out_ready = 1'b0;
    issue(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, ib);
    wb(1'b1, 5'd5, 32'h0000_5555);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", in_ready, 0);
      tick();
      wb(1'b0, 5'd0, 32'h0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_rs1", out_rs1, 32'h0000_1234);
      chk("stall_out_instr", out_instr, ia);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    tick();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_out_rs1", out_rs1, 32'hDEAD_BEEF);
    chk("b2b_out_rs2", out_rs2, 32'h0000_5555);
    chk("b2b_out_rd", {out_rd_we, out_rd_addr}, {1'b1, 5'd10});
    chk("b2b_out_instr", out_instr, ib);

    // same-cycle writer of x9 and write-back to x9: set wins
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, ia);
    wb(1'b1, 5'd9, 32'h0000_0099);
    #1;
    chk("x9_issue_ready", in_ready, 1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 5'd0, 1'b0, ib);
    tick();
    chk("x9_rf_updated", out_rs2, 32'h0000_0099);
    issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, ia);
    #1;
    chk("x9_busy_stall", in_ready, 0);
    wb(1'b1, 5'd9, 32'h0000_0ABC);
    #1;
    chk("x9_ready_on_wb", in_ready, 1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    chk("x9_bypass_rs1", out_rs1, 32'h0000_0ABC);

    // reset while busy[3] pending and output held
    issue(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, ib);
    tick();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    out_ready = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_instr", out_instr, 0);
    out_ready = 1'b1;
    issue(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, ia);
    #1;
    chk("midrst_x3_ready", in_ready, 1);
    tick();
    issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, '0);
    chk("midrst_accept_valid", out_valid, 1);
    chk("midrst_x3_zero", out_rs1, 0);
    chk("midrst_x5_zero", out_rs2, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
